serializador_paralelo_serial: RTL and testbench
===============================================

Name: serializador_paralelo_serial

Overview:
- Parallel-in, serial-out transmitter. It is the sending end of the serial link whose receiver shifts each incoming bit into its MSB and shifts the word right.
- Accepts an N_BITS word through a valid/ready load handshake, then drives it LSB-first, one bit per clk.
- A receiver that shifts for N_BITS cycles while serie_valid is high reconstructs the original word.
- Sits between the parallel datapath and the serial wire.

Parameters:
- N_BITS, 4: data word width; must be >= 2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  reset, asynchronous, active-high.
- load_valid  input  1  Din is valid for capture.
- load_ready  output  1  block can accept a word this cycle.
- Din  input  N_BITS  parallel word to transmit.
- Dout_serie  output  1  serial data bit, LSB first.
- serie_valid  output  1  Dout_serie carries a frame bit this cycle; drives the receiver's SEL.
- last_bit  output  1  current bit is the final bit of the frame.
- busy  output  1  frame in progress; equals serie_valid.

Behaviour:
- Reset (async, dominates clk):
  - state=IDLE, shift register=0, bit counter=0.
  - Dout_serie=0, serie_valid=0, last_bit=0, busy=0, load_ready=1.
  - Counter/state resolve to IDLE immediately when reset asserts.
- FSM states: IDLE, SHIFT; PARITY only when the optional feature is enabled.
- IDLE:
  - load_ready=1, serie_valid=0, Dout_serie=0.
  - load_valid=1 at a posedge: capture Din into sreg, cnt<=0, go to SHIFT.
- SHIFT:
  - Dout_serie=sreg[0], serie_valid=1.
  - Each posedge: sreg<=sreg>>1 (MSB filled with 0), cnt<=cnt+1.
  - last_bit=1 when cnt==N_BITS-1.
  - At the posedge with cnt==N_BITS-1: go to IDLE, or to PARITY if the feature is enabled.
- Load acceptance:
  - Data bits appear on Dout_serie starting the cycle after the accepting edge.
  - Bit i is valid in cycle i+1 after that edge, for i=0..N_BITS-1.
- Back-to-back:
  - load_ready is also 1 during the final frame cycle: last_bit=1 in SHIFT, or in PARITY when enabled.
  - load_valid=1 in that cycle: the new word loads at the same edge, state goes to SHIFT, cnt=0.
  - Result is zero idle gap; serie_valid stays high.
- load_ready=0 in all other SHIFT cycles. load_valid there is ignored and Din is not sampled; the sender must hold the word.
- cnt width: $clog2(N_BITS+1). cnt never exceeds N_BITS.
- Outputs are combinational from registered state and sreg only; no input-to-output combinational path except load_valid-independent load_ready.
- Reset mid-frame: the frame is abandoned and outputs return to reset values asynchronously. No partial resume after reset deasserts.

Optional Feature:
- Macro SER_PARITY_EN.
- Defined:
  - After the N_BITS data bits, one extra PARITY cycle drives Dout_serie = even parity (XOR) of the captured word, with serie_valid=1.
  - last_bit=1 only in the PARITY cycle, not on data bit N_BITS-1.
  - Frame length is N_BITS+1. Parity is computed from Din at capture and held in a register.
- Undefined: no PARITY state or parity register; frame length is N_BITS and last_bit is on the final data bit.

Decomposition:
- Package ser_pkg:
  - typedef enum logic [1:0] state_t {IDLE, SHIFT, PARITY}.
  - Function cnt_width(n) returning $clog2(n+1).
- No sub-module; the counter and FSM are inline.

Test Plan:
- N_BITS=4, Din=4'b1011, load_valid pulse in IDLE -> Dout_serie 1,1,0,1 over next 4 cycles; serie_valid=1 for exactly 4 cycles; last_bit on 4th; then IDLE with load_ready=1.
- Loopback to a receiver with Din_serie=Dout_serie and SEL=serie_valid, word 4'b0110 -> receiver Dout=4'b0110 after the 4th shift edge.
- Back-to-back 4'hA then 4'h5, second load_valid in the last_bit cycle -> continuous stream 0,1,0,1,1,0,1,0 with serie_valid never dropping.
- load_valid=1 with Din=4'hF during cycle 2 of a 4'h0 frame -> ignored; output 0,0,0,0 and a return to IDLE.
- reset asserted mid-frame between edges -> serie_valid/Dout_serie/busy go 0 immediately; after release a new 4'h3 frame yields 1,1,0,0.
- SER_PARITY_EN, Din=4'b1011 -> 1,1,0,1,1 over 5 cycles; last_bit only on 5th. Din=4'b0011 -> parity bit 0.

Source files
------------

// File: rtl/ser_pkg.sv
// ser_pkg: shared FSM state type and counter sizing helper for the serial transmitter.
package ser_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/serializador_paralelo_serial.sv
// serializador_paralelo_serial: parallel-in, LSB-first serial transmitter with valid/ready load.
// Define SER_PARITY_EN to append an even-parity bit to every frame.
module serializador_paralelo_serial
  import ser_pkg::*;
#(
  parameter int N_BITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [N_BITS-1:0] Din,
  output logic              Dout_serie,
  output logic              serie_valid,
  output logic              last_bit,
  output logic              busy
);
  localparam int CW = cnt_width(N_BITS);
  state_t            state;
  logic [N_BITS-1:0] sreg;
  logic [CW-1:0]     cnt;
  logic              fin;
  assign fin = state == SHIFT && cnt == CW'(N_BITS - 1);
`ifdef SER_PARITY_EN
  logic par;
  assign last_bit   = state == PARITY;
  assign Dout_serie = state == SHIFT ? sreg[0] : state == PARITY ? par : 1'b0;
`else
  assign last_bit   = fin;
  assign Dout_serie = state == SHIFT ? sreg[0] : 1'b0;
`endif
  assign serie_valid = state != IDLE;
  assign busy        = serie_valid;
  assign load_ready  = state == IDLE || last_bit;
  // A load in the final frame cycle takes priority, giving gap-free back-to-back frames.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
`ifdef SER_PARITY_EN
      par   <= 1'b0;
`endif
    end else if (load_valid && load_ready) begin
      state <= SHIFT;
      sreg  <= Din;
      cnt   <= '0;
`ifdef SER_PARITY_EN
      par   <= ^Din;
`endif
    end else if (state == SHIFT) begin
      sreg <= sreg >> 1;
      cnt  <= cnt + CW'(1);
`ifdef SER_PARITY_EN
      if (fin) state <= PARITY;
`else
      if (fin) state <= IDLE;
`endif
    end else if (state == PARITY) begin
      state <= IDLE;
    end
endmodule

// File: tb/tb_serializador_paralelo_serial.sv
// tb_serializador_paralelo_serial: scoreboard bench; driver queues expected serial bits per accepted word, monitor pops and compares.
module tb_serializador_paralelo_serial;
  localparam int N = 4;
`ifdef SER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  typedef struct {
    logic         b;
    logic         last;
    logic         data;
    logic         fin;
    logic [N-1:0] word;
  } exp_t;
  logic clk = 1'b0, reset = 1'b1, load_valid = 1'b0;
  logic [N-1:0] din = '0;
  logic load_ready, dout_serie, serie_valid, last_bit, busy;
  exp_t q[$];
  logic pend = 1'b0;
  logic [N-1:0] pend_w = '0;
  logic [N-1:0] rx = '0;
  logic acc;
  int errors = 0, checks = 0;

  serializador_paralelo_serial #(.N_BITS(N)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .Din(din), .Dout_serie(dout_serie), .serie_valid(serie_valid),
    .last_bit(last_bit), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_ready();
    return q.size() == 0 || q[0].last;
  endfunction

  task automatic push_frame(input logic [N-1:0] w);
    for (int i = 0; i < N; i++)
      q.push_back('{b: w[i], last: (i == N - 1) && !PAR, data: 1'b1, fin: i == N - 1, word: w});
    if (PAR) q.push_back('{b: ^w, last: 1'b1, data: 1'b0, fin: 1'b0, word: w});
  endtask

  // One clock cycle: commit the word accepted at this edge, then drive inputs for the next one.
  task automatic cycle(input logic lv, input logic [N-1:0] d, output logic a);
    @(posedge clk);
    if (pend) begin
      push_frame(pend_w);
      pend = 1'b0;
    end
    #1;
    load_valid = lv;
    din = d;
    a = lv && model_ready();
    if (a) begin
      pend = 1'b1;
      pend_w = d;
    end
  endtask

  task automatic send(input logic [N-1:0] w);
    int tries = 0;
    do begin
      cycle(1'b1, w, acc);
      tries++;
    end while (!acc && tries < 20);
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, N'($urandom), acc);
  endtask

  task automatic reset_mid_frame();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("rst_serie_valid", serie_valid, 0);
    chk("rst_dout", dout_serie, 0);
    chk("rst_busy", busy, 0);
    chk("rst_last_bit", last_bit, 0);
    chk("rst_load_ready", load_ready, 1);
    q.delete();
    pend = 1'b0;
    load_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    chk("serie_valid", serie_valid, q.size() != 0);
    chk("busy", busy, q.size() != 0);
    chk("load_ready", load_ready, model_ready());
    if (q.size() != 0) begin
      chk("dout_serie", dout_serie, q[0].b);
      chk("last_bit", last_bit, q[0].last);
      if (q[0].data) rx = {dout_serie, rx[N-1:1]};
      if (q[0].fin) chk("loopback_word", rx, q[0].word);
      void'(q.pop_front());
    end else begin
      chk("idle_dout", dout_serie, 0);
      chk("idle_last_bit", last_bit, 0);
    end
  end

  initial begin
    #1;
    chk("reset_serie_valid", serie_valid, 0);
    chk("reset_load_ready", load_ready, 1);
    chk("reset_dout", dout_serie, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    send(4'b1011);
    idle(N + 3);
    send(4'b0110);
    idle(N + 3);
    send(4'hA);
    send(4'h5);
    idle(N + 3);
    send(4'h0);
    cycle(1'b0, 4'h0, acc);
    cycle(1'b1, 4'hF, acc);
    chk("busy_load_ignored", acc, 0);
    idle(N + 3);
    send(4'b0011);
    idle(N + 3);
    send(4'h6);
    idle(1);
    reset_mid_frame();
    send(4'h3);
    idle(N + 3);
    for (int i = 0; i < 300; i++) cycle($urandom_range(0, 2) != 0, N'($urandom), acc);
    idle(N + 4);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
